// File: rtl/iprf_wb_arbiter_pkg.sv
// Shared writeback types and sizing helpers for the integer regfile writeback arbiter.
package iprf_wb_arbiter_pkg;

  localparam int IPR_IDX_W = 7;
  localparam int XDEF      = 64;

  typedef logic [IPR_IDX_W-1:0] ipr_idx_t;

  typedef struct packed {
    ipr_idx_t          iprd_idx;
    logic [XDEF-1:0]   result;
  } wb_req_t;

  localparam int IPRF_WB_SRCS  = 8;
  localparam int IPRF_WB_PORTS = 6;

  // Index/pointer width for n items; a single item still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/iprf_wb_arbiter_if.sv
// Writeback source and regfile write-port bundle between FUs, the arbiter and the regfile.
interface iprf_wb_arbiter_if #(
  parameter int SRC_NUM   = 8,
  parameter int WPORT_NUM = 6,
  parameter int DATA_W    = 64,
  parameter int IDX_W     = 7
);
  // Source handshake: an entry transfers at a rising edge where i_src_vld[s] and
  // o_src_rdy[s] are both high; o_src_rdy never depends on i_src_vld in the same cycle.
  logic [SRC_NUM-1:0]              i_src_vld;
  logic [SRC_NUM-1:0]              o_src_rdy;
  logic [SRC_NUM-1:0]              i_src_wen;
  logic [SRC_NUM-1:0][IDX_W-1:0]   i_src_idx;
  logic [SRC_NUM-1:0][DATA_W-1:0]  i_src_data;
  logic [WPORT_NUM-1:0]            o_wp_vld;
  logic [WPORT_NUM-1:0][IDX_W-1:0] o_wp_idx;
  logic [WPORT_NUM-1:0][DATA_W-1:0] o_wp_data;

  modport slave (
    input  i_src_vld, i_src_wen, i_src_idx, i_src_data,
    output o_src_rdy, o_wp_vld, o_wp_idx, o_wp_data
  );

  modport master (
    output i_src_vld, i_src_wen, i_src_idx, i_src_data,
    input  o_src_rdy, o_wp_vld, o_wp_idx, o_wp_data
  );
endinterface

// File: rtl/iprf_wb_arbiter_wb_src_fifo.sv
// Per-source writeback FIFO; pointers wrap at DEPTH so any depth works.
module wb_src_fifo
  import iprf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 71
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         enq,
  input  logic [W-1:0] enq_data,
  input  logic         deq,
  output logic [W-1:0] head,
  output logic         not_empty,
  output logic         not_full
);
  localparam int CW = cnt_w(DEPTH);
  localparam int PW = idx_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [W-1:0]  mem [DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= ptr_inc(wr_ptr);
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      if (enq && !deq)      count <= count + CW'(1);
      else if (deq && !enq) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: the head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (enq && !flush) mem[wr_ptr] <= enq_data;
  end

  assign head      = mem[rd_ptr];
  assign not_empty = (count != '0);
  assign not_full  = (count != FULL);

endmodule

// File: rtl/iprf_wb_arbiter.sv
// Round-robin multi-grant writeback arbiter: SRC_NUM buffered sources onto WPORT_NUM
// registered regfile write ports, with a saturating port-conflict counter.
module iprf_wb_arbiter
  import iprf_wb_arbiter_pkg::*;
#(
  parameter int SRC_NUM   = IPRF_WB_SRCS,
  parameter int WPORT_NUM = IPRF_WB_PORTS,
  parameter int BUF_DEPTH = 2,
  parameter int DATA_W    = XDEF,
  parameter int IDX_W     = IPR_IDX_W,
  parameter int HAS_ZERO  = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  iprf_wb_arbiter_if.slave bus,
  output logic [CNT_W-1:0] o_conflict_cnt
);
  localparam int ENT_W = IDX_W + DATA_W;
  localparam int RR_W  = idx_w(SRC_NUM);

  logic [SRC_NUM-1:0]               not_empty;
  logic [SRC_NUM-1:0]               not_full;
  logic [SRC_NUM-1:0]               enq;
  logic [SRC_NUM-1:0]               deq;
  logic [SRC_NUM-1:0][ENT_W-1:0]    head;
  logic [RR_W-1:0]                  rr_ptr;
  logic [RR_W-1:0]                  rr_nxt;
  logic                             any_grant;
  logic                             conflict;
  logic [WPORT_NUM-1:0]             port_vld;
  logic [WPORT_NUM-1:0][IDX_W-1:0]  port_idx;
  logic [WPORT_NUM-1:0][DATA_W-1:0] port_data;

  // Ready comes from FIFO occupancy only, forced low while in reset.
  assign bus.o_src_rdy = not_full & {SRC_NUM{rst}};

  for (genvar s = 0; s < SRC_NUM; s++) begin : g_src
    // Handshakes without a real register write complete but never occupy a slot.
    assign enq[s] = bus.i_src_vld[s] & not_full[s] & rst & bus.i_src_wen[s]
                  & ~((HAS_ZERO != 0) && (bus.i_src_idx[s] == '0));

    wb_src_fifo #(
      .DEPTH (BUF_DEPTH),
      .W     (ENT_W)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (i_flush),
      .enq       (enq[s]),
      .enq_data  ({bus.i_src_idx[s], bus.i_src_data[s]}),
      .deq       (deq[s]),
      .head      (head[s]),
      .not_empty (not_empty[s]),
      .not_full  (not_full[s])
    );
  end

  // Scan from rr_ptr; the k-th eligible source found lands on port k.
  always_comb begin
    int src;
    int ng;
    int n_elig;
    int last;
    deq       = '0;
    port_vld  = '0;
    port_idx  = '0;
    port_data = '0;
    ng        = 0;
    n_elig    = 0;
    last      = int'(rr_ptr);
    src       = 0;
    for (int k = 0; k < SRC_NUM; k++) begin
      src = int'(rr_ptr) + k;
      if (src >= SRC_NUM) src = src - SRC_NUM;
      if (not_empty[src]) begin
        n_elig = n_elig + 1;
        if (ng < WPORT_NUM) begin
          deq[src]      = 1'b1;
          port_vld[ng]  = 1'b1;
          port_idx[ng]  = head[src][ENT_W-1:DATA_W];
          port_data[ng] = head[src][DATA_W-1:0];
          ng            = ng + 1;
          last          = src;
        end
      end
    end
    any_grant = (ng != 0);
    conflict  = (n_elig > WPORT_NUM);
    rr_nxt    = (last == SRC_NUM - 1) ? '0 : RR_W'(last + 1);
  end

  // Flush drops this cycle's grants and holds the round-robin position and counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr         <= '0;
      bus.o_wp_vld   <= '0;
      bus.o_wp_idx   <= '0;
      bus.o_wp_data  <= '0;
      o_conflict_cnt <= '0;
    end else if (i_flush) begin
      bus.o_wp_vld   <= '0;
      bus.o_wp_idx   <= '0;
      bus.o_wp_data  <= '0;
    end else begin
      if (any_grant) rr_ptr <= rr_nxt;
      bus.o_wp_vld  <= port_vld;
      bus.o_wp_idx  <= port_idx;
      bus.o_wp_data <= port_data;
      if (conflict && (o_conflict_cnt != '1)) o_conflict_cnt <= o_conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_iprf_wb_arbiter.sv
// Bench for iprf_wb_arbiter: an 8-source/6-port instance and a 2-source/1-port instance
// (no zero-index filtering, 3-bit counter) against a queue-based reference model.
`timescale 1ns/1ps
module tb_iprf_wb_arbiter;
  localparam int DW = 64;
  localparam int IW = 7;
  localparam int EW = IW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- generic per-instance views (u=0: 8x6, u=1: 2x1) ----------------
  logic                flush    [2];
  logic [7:0]          src_vld  [2];
  logic [7:0]          src_wen  [2];
  logic [7:0][IW-1:0]  src_idx  [2];
  logic [7:0][DW-1:0]  src_data [2];
  logic [7:0]          rdy_o    [2];
  logic [5:0]          wp_vld_o [2];
  logic [5:0][IW-1:0]  wp_idx_o [2];
  logic [5:0][DW-1:0]  wp_data_o[2];
  logic [31:0]         cnt_o    [2];
  logic [31:0]         cnt0;
  logic [2:0]          cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  iprf_wb_arbiter_if #(.SRC_NUM(8), .WPORT_NUM(6), .DATA_W(DW), .IDX_W(IW)) if0 ();
  iprf_wb_arbiter_if #(.SRC_NUM(2), .WPORT_NUM(1), .DATA_W(DW), .IDX_W(IW)) if1 ();

  iprf_wb_arbiter dut0 (
    .clk(clk), .rst(rst), .i_flush(flush[0]), .bus(if0), .o_conflict_cnt(cnt0)
  );

  iprf_wb_arbiter #(
    .SRC_NUM(2), .WPORT_NUM(1), .BUF_DEPTH(2), .DATA_W(DW), .IDX_W(IW),
    .HAS_ZERO(0), .CNT_W(3)
  ) dut1 (
    .clk(clk), .rst(rst), .i_flush(flush[1]), .bus(if1), .o_conflict_cnt(cnt1)
  );

  assign if0.i_src_vld  = src_vld[0];
  assign if0.i_src_wen  = src_wen[0];
  assign if0.i_src_idx  = src_idx[0];
  assign if0.i_src_data = src_data[0];
  assign if1.i_src_vld  = src_vld[1][1:0];
  assign if1.i_src_wen  = src_wen[1][1:0];
  assign if1.i_src_idx  = src_idx[1][1:0];
  assign if1.i_src_data = src_data[1][1:0];

  assign rdy_o[0]     = if0.o_src_rdy;
  assign rdy_o[1]     = {6'b0, if1.o_src_rdy};
  assign wp_vld_o[0]  = if0.o_wp_vld;
  assign wp_vld_o[1]  = {5'b0, if1.o_wp_vld};
  assign wp_idx_o[0]  = if0.o_wp_idx;
  assign wp_idx_o[1]  = {{5{7'b0}}, if1.o_wp_idx};
  assign wp_data_o[0] = if0.o_wp_data;
  assign wp_data_o[1] = {{5{64'b0}}, if1.o_wp_data};
  assign cnt_o[0]     = cnt0;
  assign cnt_o[1]     = {29'b0, cnt1};

  // ---------------- reference model ----------------
  // exp_q[u*8+s] holds the buffered {idx,data} entries of source s of instance u.
  logic [EW-1:0]      exp_q [16][$];
  int                 m_rr  [2];
  int                 m_acc [2];
  logic [5:0]         m_vld [2];
  logic [5:0][IW-1:0] m_idx [2];
  logic [5:0][DW-1:0] m_data[2];
  logic [31:0]        m_cnt [2];

  function automatic int ns_of(input int u);   return (u == 0) ? 8 : 2; endfunction
  function automatic int nw_of(input int u);   return (u == 0) ? 6 : 1; endfunction
  function automatic int hz_of(input int u);   return (u == 0) ? 1 : 0; endfunction
  function automatic logic [31:0] cmax_of(input int u);
    return (u == 0) ? 32'hFFFF_FFFF : 32'd7;
  endfunction

  function automatic logic [7:0] m_rdy(input int u);
    logic [7:0] r = '0;
    for (int s = 0; s < ns_of(u); s++) r[s] = rst && (exp_q[u*8+s].size() != 2);
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) exp_q[i].delete();
    for (int u = 0; u < 2; u++) begin
      m_rr[u] = 0; m_acc[u] = 0; m_vld[u] = '0; m_idx[u] = '0; m_data[u] = '0; m_cnt[u] = '0;
    end
  endtask

  task automatic model_step(input int u);
    int ns = ns_of(u);
    int nw = nw_of(u);
    int elig = 0;
    int ng = 0;
    int last = 0;
    logic [7:0] rdy_pre = m_rdy(u);
    logic [EW-1:0] e;
    for (int s = 0; s < ns; s++) if (exp_q[u*8+s].size() != 0) elig++;
    m_vld[u] = '0; m_idx[u] = '0; m_data[u] = '0;
    if (flush[u]) begin
      for (int s = 0; s < ns; s++) exp_q[u*8+s].delete();
    end else begin
      if (elig > nw && m_cnt[u] != cmax_of(u)) m_cnt[u] = m_cnt[u] + 1;
      for (int k = 0; k < ns; k++) begin
        int s = (m_rr[u] + k) % ns;
        if (ng < nw && exp_q[u*8+s].size() != 0) begin
          e = exp_q[u*8+s].pop_front();
          m_vld[u][ng]  = 1'b1;
          m_idx[u][ng]  = e[EW-1:DW];
          m_data[u][ng] = e[DW-1:0];
          ng++;
          last = s;
        end
      end
      if (ng > 0) m_rr[u] = (last + 1) % ns;
      for (int s = 0; s < ns; s++) begin
        if (src_vld[u][s] && rdy_pre[s] && src_wen[u][s] &&
            !(hz_of(u) == 1 && src_idx[u][s] == '0)) begin
          exp_q[u*8+s].push_back({src_idx[u][s], src_data[u][s]});
          m_acc[u]++;
        end
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_clear();
      else for (int u = 0; u < 2; u++) model_step(u);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    for (int u = 0; u < 2; u++) begin
      flush[u] = 1'b0; src_vld[u] = '0; src_wen[u] = '0; src_idx[u] = '0; src_data[u] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_random(input int u, input logic [7:0] mask, input bit nonzero);
    src_vld[u] = mask;
    src_wen[u] = mask;
    for (int s = 0; s < 8; s++) begin
      src_idx[u][s]  = nonzero ? IW'($urandom_range(1, 127)) : IW'($urandom_range(0, 127));
      src_data[u][s] = {$urandom(), $urandom()};
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (rdy_o[0] !== 8'h00 || rdy_o[1] !== 8'h00) begin
      n_fail++; $display("FAIL reset_rdy: got %h/%h want 00/00", rdy_o[0], rdy_o[1]);
    end
    n_checks++;
    if (wp_vld_o[0] !== 6'h0 || wp_vld_o[1] !== 6'h0 || cnt_o[0] !== 0 || cnt_o[1] !== 0) begin
      n_fail++; $display("FAIL reset_out: vld %h/%h cnt %0d/%0d want 0", wp_vld_o[0], wp_vld_o[1], cnt_o[0], cnt_o[1]);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (rdy_o[0] !== 8'hFF || rdy_o[1] !== 8'h03 || wp_vld_o[0] !== 6'h0 || cnt_o[0] !== 0) begin
      n_fail++; $display("FAIL idle: rdy %h/%h vld %h cnt %0d want FF/03 0 0", rdy_o[0], rdy_o[1], wp_vld_o[0], cnt_o[0]);
    end
  endtask

  task automatic test_conflict_rr();
    src_vld[0] = 8'hFF;
    src_wen[0] = 8'hFF;
    for (int s = 0; s < 8; s++) begin
      src_idx[0][s]  = IW'(s + 1);
      src_data[0][s] = 64'h1000 + 64'(s);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (wp_vld_o[0] !== 6'h00 || rdy_o[0] !== 8'hFF) begin
      n_fail++; $display("FAIL conflict_accept: vld %h rdy %h want 00 FF", wp_vld_o[0], rdy_o[0]);
    end
    tick();
    n_checks++;
    if (wp_vld_o[0] !== 6'h3F || cnt_o[0] !== 32'd1) begin
      n_fail++; $display("FAIL conflict_first: vld %h cnt %0d want 3f 1", wp_vld_o[0], cnt_o[0]);
    end
    for (int p = 0; p < 6; p++) begin
      n_checks++;
      if (wp_idx_o[0][p] !== IW'(p + 1) || wp_data_o[0][p] !== 64'h1000 + 64'(p)) begin
        n_fail++; $display("FAIL conflict_port%0d: idx %0d data %h want %0d %h", p, wp_idx_o[0][p], wp_data_o[0][p], p + 1, 64'h1000 + 64'(p));
      end
    end
    tick();
    n_checks++;
    if (wp_vld_o[0] !== 6'h03 || wp_idx_o[0][0] !== 7'd7 || wp_idx_o[0][1] !== 7'd8 ||
        wp_data_o[0][0] !== 64'h1006 || wp_data_o[0][1] !== 64'h1007 || cnt_o[0] !== 32'd1) begin
      n_fail++; $display("FAIL conflict_second: vld %h idx %0d,%0d cnt %0d want 03 7,8 1", wp_vld_o[0], wp_idx_o[0][0], wp_idx_o[0][1], cnt_o[0]);
    end
    tick();
    n_checks++;
    if (wp_vld_o[0] !== 6'h00 || cnt_o[0] !== 32'd1) begin
      n_fail++; $display("FAIL conflict_idle: vld %h cnt %0d want 00 1", wp_vld_o[0], cnt_o[0]);
    end
  endtask

  task automatic test_single_latency();
    src_vld[0][2]  = 1'b1;
    src_wen[0][2]  = 1'b1;
    src_idx[0][2]  = 7'd5;
    src_data[0][2] = 64'hABCD;
    tick();
    idle_inputs();
    n_checks++;
    if (wp_vld_o[0] !== 6'h00) begin
      n_fail++; $display("FAIL latency_early: vld %h want 00", wp_vld_o[0]);
    end
    tick();
    n_checks++;
    if (wp_vld_o[0] !== 6'h01 || wp_idx_o[0][0] !== 7'd5 || wp_data_o[0][0] !== 64'hABCD) begin
      n_fail++; $display("FAIL latency_write: vld %h idx %0d data %h want 01 5 abcd", wp_vld_o[0], wp_idx_o[0][0], wp_data_o[0][0]);
    end
    tick();
    n_checks++;
    if (wp_vld_o[0] !== 6'h00) begin
      n_fail++; $display("FAIL latency_once: vld %h want 00", wp_vld_o[0]);
    end
  endtask

  task automatic test_zero_filter();
    src_vld[0][3] = 1'b1;
    src_wen[0][3] = 1'b1;
    src_idx[0][3] = 7'd0;
    n_checks++;
    if (rdy_o[0][3] !== 1'b1) begin
      n_fail++; $display("FAIL filter_rdy_zero: rdy %b want 1", rdy_o[0][3]);
    end
    tick();
    src_wen[0][3] = 1'b0;
    src_idx[0][3] = 7'd9;
    n_checks++;
    if (rdy_o[0][3] !== 1'b1) begin
      n_fail++; $display("FAIL filter_rdy_nowen: rdy %b want 1", rdy_o[0][3]);
    end
    tick();
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (wp_vld_o[0] !== 6'h00 || rdy_o[0] !== 8'hFF) begin
        n_fail++; $display("FAIL filter_quiet cyc %0d: vld %h rdy %h want 00 FF", c, wp_vld_o[0], rdy_o[0]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] saw_full = 2'b00;
    int wr = 0;
    int acc0 = m_acc[1];
    for (int c = 0; c < 48; c++) begin
      if (c < 40) push_random(1, 8'h03, 1'b0);
      else idle_inputs();
      tick();
      saw_full = saw_full | ~rdy_o[1][1:0];
      wr += $countones(wp_vld_o[1]);
      n_checks++;
      if (wp_vld_o[1] !== m_vld[1] || rdy_o[1] !== m_rdy(1) || cnt_o[1] !== m_cnt[1]) begin
        n_fail++; $display("FAIL backpressure cyc %0d: vld %h rdy %h cnt %0d want %h %h %0d", c, wp_vld_o[1], rdy_o[1], cnt_o[1], m_vld[1], m_rdy(1), m_cnt[1]);
      end
      if (m_vld[1][0]) begin
        n_checks++;
        if (wp_idx_o[1][0] !== m_idx[1][0] || wp_data_o[1][0] !== m_data[1][0]) begin
          n_fail++; $display("FAIL backpressure_data cyc %0d: idx %0d data %h want %0d %h", c, wp_idx_o[1][0], wp_data_o[1][0], m_idx[1][0], m_data[1][0]);
        end
      end
    end
    n_checks++;
    if (saw_full !== 2'b11) begin
      n_fail++; $display("FAIL backpressure_rdy_drop: saw %b want 11", saw_full);
    end
    n_checks++;
    if (wr != m_acc[1] - acc0) begin
      n_fail++; $display("FAIL backpressure_lossless: wrote %0d want %0d", wr, m_acc[1] - acc0);
    end
    n_checks++;
    if (cnt_o[1] !== 32'd7) begin
      n_fail++; $display("FAIL counter_saturate: cnt %0d want 7", cnt_o[1]);
    end
  endtask

  task automatic test_flush();
    logic [31:0] cnt_before;
    for (int c = 0; c < 5; c++) begin
      push_random(0, 8'hFF, 1'b1);
      tick();
    end
    n_checks++;
    if (rdy_o[0] !== m_rdy(0)) begin
      n_fail++; $display("FAIL flush_fill: rdy %h want %h", rdy_o[0], m_rdy(0));
    end
    cnt_before = m_cnt[0];
    flush[0] = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (rdy_o[0] !== 8'hFF || wp_vld_o[0] !== 6'h00 || cnt_o[0] !== cnt_before) begin
      n_fail++; $display("FAIL flush_clear: rdy %h vld %h cnt %0d want FF 00 %0d", rdy_o[0], wp_vld_o[0], cnt_o[0], cnt_before);
    end
    tick();
    n_checks++;
    if (wp_vld_o[0] !== 6'h00) begin
      n_fail++; $display("FAIL flush_empty: vld %h want 00", wp_vld_o[0]);
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 3; c++) begin
      push_random(0, 8'hFF, 1'b1);
      push_random(1, 8'h03, 1'b0);
      tick();
    end
    #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if (wp_vld_o[0] !== 6'h00 || wp_vld_o[1] !== 6'h00 || rdy_o[0] !== 8'h00 ||
        rdy_o[1] !== 8'h00 || cnt_o[0] !== 0 || cnt_o[1] !== 0) begin
      n_fail++; $display("FAIL async_reset: vld %h/%h rdy %h/%h cnt %0d/%0d want all 0", wp_vld_o[0], wp_vld_o[1], rdy_o[0], rdy_o[1], cnt_o[0], cnt_o[1]);
    end
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (rdy_o[0] !== 8'hFF || rdy_o[1] !== 8'h03 || wp_vld_o[0] !== 6'h00 || wp_vld_o[1] !== 6'h00) begin
      n_fail++; $display("FAIL async_release: rdy %h/%h vld %h/%h want FF/03 00/00", rdy_o[0], rdy_o[1], wp_vld_o[0], wp_vld_o[1]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int u = 0; u < 2; u++) begin
        src_vld[u] = (u == 0) ? 8'($urandom()) : {6'b0, 2'($urandom())};
        for (int s = 0; s < 8; s++) begin
          src_wen[u][s]  = ($urandom_range(0, 7) != 0);
          src_idx[u][s]  = ($urandom_range(0, 7) == 0) ? '0 : IW'($urandom_range(1, 127));
          src_data[u][s] = {$urandom(), $urandom()};
        end
        flush[u] = ($urandom_range(0, 31) == 0);
      end
      tick();
      for (int u = 0; u < 2; u++) begin
        n_checks++;
        if (wp_vld_o[u] !== m_vld[u] || rdy_o[u] !== m_rdy(u) || cnt_o[u] !== m_cnt[u]) begin
          n_fail++; $display("FAIL random u%0d cyc %0d: vld %h rdy %h cnt %0d want %h %h %0d", u, c, wp_vld_o[u], rdy_o[u], cnt_o[u], m_vld[u], m_rdy(u), m_cnt[u]);
        end
        for (int p = 0; p < 6; p++) begin
          if (m_vld[u][p]) begin
            n_checks++;
            if (wp_idx_o[u][p] !== m_idx[u][p] || wp_data_o[u][p] !== m_data[u][p]) begin
              n_fail++; $display("FAIL random_data u%0d cyc %0d port %0d: idx %0d data %h want %0d %h", u, c, p, wp_idx_o[u][p], wp_data_o[u][p], m_idx[u][p], m_data[u][p]);
            end
          end
        end
      end
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_conflict_rr();
    test_single_latency();
    test_zero_filter();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iprf_wb_arbiter.md
Name: iprf_wb_arbiter

Overview:
- Parametrised writeback arbiter between SRC_NUM functional-unit writeback sources and WPORT_NUM integer physical-regfile write ports.
- Sits in the execute block between the FU writeback outputs and the regfile write ports, replacing the fixed 1:1 FU-to-port wiring.
- Each source has a BUF_DEPTH FIFO with a valid/ready handshake; a round-robin arbiter drains up to WPORT_NUM entries per cycle to registered write ports.
- Keeps a saturating port-conflict performance counter.

Parameters:
SRC_NUM, 8, number of writeback sources (>=1)
WPORT_NUM, 6, number of regfile write ports (1..SRC_NUM)
BUF_DEPTH, 2, entries per source FIFO (>=1, power of two not required)
DATA_W, 64, writeback data width
IDX_W, 7, physical register index width
HAS_ZERO, 1, 1 = writes to index 0 are discarded at enqueue
CNT_W, 32, perf counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
i_flush  in  1  drop all buffered entries
i_src_vld  in  SRC_NUM  source writeback valid
o_src_rdy  out  SRC_NUM  source FIFO can accept
i_src_wen  in  SRC_NUM  source writes a register
i_src_idx  in  SRC_NUM x IDX_W  destination physical register
i_src_data  in  SRC_NUM x DATA_W  result
o_wp_vld  out  WPORT_NUM  write port enable (registered)
o_wp_idx  out  WPORT_NUM x IDX_W  write port index (registered)
o_wp_data  out  WPORT_NUM x DATA_W  write port data (registered)
o_conflict_cnt  out  CNT_W  saturating count of conflict cycles

Behaviour:
- Reset (rst low, asynchronous):
  - All FIFO counts, pointers and rr_ptr go to 0.
  - o_wp_vld=0; o_wp_idx/o_wp_data=0; o_conflict_cnt=0.
  - o_src_rdy=0 while rst is low.
  - Reset mid-operation discards all buffered entries.
- o_src_rdy[s] = (count[s] != BUF_DEPTH), derived from registered state only. There is no combinational path from grant or inputs.
- Accept occurs when i_src_vld[s] & o_src_rdy[s] are both high at a rising edge.
  - The entry is enqueued only if i_src_wen[s]=1 and not (HAS_ZERO && i_src_idx[s]==0).
  - Otherwise the handshake completes and the entry is discarded.
- Source s is eligible in a cycle if count[s]!=0; its FIFO head is presented combinationally.
- Grant:
  - Scan sources in order rr_ptr, rr_ptr+1, ... (mod SRC_NUM).
  - The first min(WPORT_NUM, eligible) eligible sources are granted, one entry each.
  - The k-th grant in scan order drives port k; ports without a grant get vld=0 at the next edge.
- rr_ptr update: if any grant, rr_ptr <= (last granted source + 1) mod SRC_NUM; otherwise unchanged.
- Latency: accept at edge E0 -> head eligible in the cycle after E0 -> o_wp_* driven from edge E1. Minimum 2 cycles from presenting valid to write-port visibility.
- Simultaneous enqueue and dequeue on one source in the same edge: count unchanged, both pointers advance. This is allowed when full: a full FIFO still dequeues, but o_src_rdy was 0, so no enqueue occurs.
- Per-source ordering is FIFO. There is no ordering guarantee across sources.
- Flush (i_flush=1 at an edge):
  - All counts and pointers go to 0; any accept in that cycle is discarded.
  - o_wp_vld <= 0 at that edge.
  - rr_ptr is held.
  - Entries granted in the flush cycle are not written.
- Conflict counter: increments by 1 at each edge where eligible sources > WPORT_NUM and i_flush=0. It saturates at all-ones, and does not reset on flush.
- Widths: count width = clog2(BUF_DEPTH+1); pointer width = max(1, clog2(BUF_DEPTH)); pointers wrap at BUF_DEPTH, including non-power-of-two depths.

Decomposition:
- Shared package (core_define/backend pkg):
  - wbReq_t {iprd_idx, result}, using existing iprIdx_t width and XDEF.
  - Constants IPRF_WB_SRCS and IPRF_WB_PORTS for exeBlock instantiation.
- Sub-module wb_src_fifo: per-source FIFO holding count/pointers/storage, with enq/deq/flush interface; instantiated SRC_NUM times.
- The round-robin multi-grant logic stays in the top level.

Test Plan:
1. Reset and idle: hold rst low 3 cycles then release with no valids -> o_wp_vld=0, o_src_rdy=all 1s, o_conflict_cnt=0.
2. Single write latency: src2 vld, idx=5, data=0xABCD for one cycle -> o_wp_vld[0]=1, idx 5, data 0xABCD, exactly 2 cycles later, one cycle only.
3. Conflict and round-robin: SRC_NUM=8, WPORT_NUM=6, all 8 sources push once in the same cycle -> first grant cycle serves srcs 0-5 on ports 0-5, next cycle srcs 6,7 on ports 0,1; o_conflict_cnt=1.
4. Backpressure: BUF_DEPTH=2, WPORT_NUM=1, src0 and src1 push every cycle -> o_src_rdy drops to 0 on each source when count=2, grants alternate src0/src1, and no entry is lost or reordered within a source.
5. Zero and no-wen filtering: HAS_ZERO=1; src3 pushes idx=0 wen=1, then idx=9 wen=0 -> both handshakes complete, no o_wp_vld ever asserted, count[3] stays 0.
6. Flush and asynchronous reset mid-operation: fill 3 sources to full, assert i_flush one cycle -> next cycle all o_src_rdy=1, o_wp_vld=0; repeat with rst asserted mid-cycle -> outputs clear immediately without a clock edge.
